// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, with valid/ready operand and result handshakes.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
    logic             carry_q, carry_d, c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s0, c0, sum_bit, c1, carry_n;
    logic [WIDTH-1:0] acc_n;

    half_adder u_ha0 (.a(a_q[0]), .b(b_q[0]), .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(carry_q), .s(sum_bit), .c(c1));

    assign carry_n   = c0 | c1;
    assign acc_n     = {sum_bit, acc_q[WIDTH-1:1]};
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == ADD);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign C         = c_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        c_d     = c_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = A;
                b_d     = B;
                carry_d = CIN;
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                acc_d   = acc_n;
                carry_d = carry_n;
                cnt_d   = cnt_q + 1'b1;
                // final bit: publish the full sum and carry-out together
                if (cnt_q == LAST) begin
                    s_d     = acc_n;
                    c_d     = carry_n;
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            c_q     <= c_d;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random operand pairs checked against plain A+B+CIN arithmetic.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, CIN = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic         in_ready, busy, out_valid, C;
    logic [W-1:0] S;
    int           errors = 0, checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .CIN(CIN), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .S(S), .C(C)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(output int t, output int n);
        t = 0;
        n = 0;
        while (!out_valid && t < 4 * W) begin
            n += int'(busy);
            t++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int hold, input bit pulse);
        logic [W:0] e;
        int t, n;
        e = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        CIN       = cin;
        out_ready = (hold == 0);
        chk("in_ready_before", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        A        = W'($urandom);
        B        = W'($urandom);
        CIN      = 1'($urandom);
        wait_out(t, n);
        chk("latency", t, W);
        chk("busy_cycles", n, W);
        chk("sum", S, e[W-1:0]);
        chk("carry", C, e[W]);
        for (int i = 0; i < hold; i++) begin
            in_valid = pulse && (i == 2);
            A        = 8'hFF;
            B        = 8'hFF;
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", S, e[W-1:0]);
            chk("bp_carry", C, e[W]);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("sum_kept", S, e[W-1:0]);
        chk("carry_kept", C, e[W]);
    endtask

    initial begin
        int t, n;
        logic [W-1:0] pat [4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_S", S, 0);
        chk("rst_C", C, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h00, 8'h00, 1'b0, 0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 0);
        run_op(8'h3C, 8'h0F, 1'b0, 5, 1);

        // reset after three ADD edges discards the operation
        in_valid = 1'b1;
        A        = 8'h12;
        B        = 8'h34;
        CIN      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_S", S, 0);
        chk("arst_C", C, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        run_op(8'h12, 8'h34, 1'b0, 0, 0);

        // back-to-back with in_valid held throughout
        in_valid  = 1'b1;
        A         = 8'h80;
        B         = 8'h80;
        CIN       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        A = 8'h01;
        B = 8'h02;
        wait_out(t, n);
        chk("b2b1_latency", t, W);
        chk("b2b1_busy", n, W);
        chk("b2b1_sum", S, 8'h00);
        chk("b2b1_carry", C, 1);
        @(negedge clk);
        chk("b2b_gap_in_ready", in_ready, 1);
        chk("b2b_gap_busy", busy, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b2_accepted", busy, 1);
        wait_out(t, n);
        chk("b2b2_latency", t, W);
        chk("b2b2_busy", n, W);
        chk("b2b2_sum", S, 8'h03);
        chk("b2b2_carry", C, 0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_end_in_ready", in_ready, 1);

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 2; k++)
                    run_op(pat[i], pat[j], k[0], 0, 0);

        for (int r = 0; r < 20; r++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder; the sequential stage that consumes half_adder sum/carry results.
- Per-bit full-add is built from two half_adder instances plus an OR for carry, with a registered carry flip-flop.
- Accepts an operand pair over a valid/ready handshake, adds LSB-first over WIDTH cycles, then presents sum and carry-out on a valid/ready output.
- Sits between an operand source, e.g. a register file or stimulus FSM, and a result consumer.

Parameters:
WIDTH, 8, operand and sum width in bits (>= 2)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair A/B/CIN valid
in_ready  output  1  block can accept operands (high only in IDLE)
A  input  WIDTH  operand A, sampled on input handshake
B  input  WIDTH  operand B, sampled on input handshake
CIN  input  1  carry-in, sampled on input handshake
busy  output  1  high while in ADD state
out_valid  output  1  S/C hold a completed result
out_ready  input  1  consumer accepts result
S  output  WIDTH  sum (registered)
C  output  1  carry-out (registered)

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, in_ready=1, busy=0, out_valid=0, S=0, C=0, internal shift registers/carry/counter=0. Reset may assert in any state, including mid-ADD or DONE. The in-flight operation is discarded and no result is produced.
- States: IDLE, ADD, DONE. in_ready = (state==IDLE), busy = (state==ADD), out_valid = (state==DONE); all are decoded from registered state.
- IDLE: on in_valid && in_ready at an edge:
  - latch A and B into shift regs; carry_ff <= CIN; bit counter <= 0; state <= ADD.
  - in_valid without handshake has no effect.
- ADD, each edge:
  - sum_bit = a[0]^b[0]^carry_ff; carry_ff <= majority(a[0], b[0], carry_ff).
  - Shift A/B regs right by 1; shift sum_bit into S-accumulator MSB (right shift), so after WIDTH steps bit i sits at S[i].
  - Counter increments. On the edge processing counter==WIDTH-1: load S from the accumulator, C <= final carry, state <= DONE.
- Latency: input handshake at edge k, out_valid high after edge k+WIDTH. Exactly WIDTH ADD cycles, independent of data.
- DONE: S and C hold stable while out_valid=1 and out_ready=0, with no limit on how long. On out_valid && out_ready at an edge: state <= IDLE, and S/C keep their last value.
- No overlap: the next input is accepted no earlier than the edge after the output handshake, so back-to-back throughput is one result per WIDTH+2 cycles.
- in_valid asserted during ADD/DONE is ignored (in_ready=0); the source must hold it.
- Arithmetic: {C,S} = A + B + CIN modulo 2^(WIDTH+1), unsigned. Wrap-around is reported only via C.
- out_ready during IDLE/ADD has no effect.

Test Plan (WIDTH=8):
- A=0x00, B=0x00, CIN=0, out_ready=1 -> out_valid exactly 8 cycles after accept, S=0x00, C=0; in_ready returns high next cycle.
- A=0xFF, B=0x01, CIN=0 -> S=0x00, C=1. A=0xA5, B=0x5A, CIN=1 -> S=0x00, C=1. A=0x7F, B=0x01, CIN=0 -> S=0x80, C=0.
- Backpressure: A=0x3C, B=0x0F, out_ready=0 for 5 cycles after out_valid -> S=0x4B, C=0 stable all 5 cycles. in_valid pulsed with new operands during DONE -> ignored, in_ready=0. Raise out_ready -> IDLE next cycle.
- Reset mid-operation: accept A=0x12, B=0x34, assert rst after 3 ADD cycles -> immediately out_valid=0, busy=0, in_ready=1, S=0, C=0. Then A=0x12, B=0x34 -> S=0x46, C=0.
- Back-to-back with out_ready=1 and in_valid held: A=0x80, B=0x80 then A=0x01, B=0x02 -> first S=0x00, C=1; second accepted the cycle after the first output handshake, S=0x03, C=0. busy high exactly 8 cycles per operation.
- Exhaustive sweep, self-checking against A+B+CIN: all 8-bit A, B in {0x00, 0x55, 0xAA, 0xFF} × CIN {0,1} -> zero mismatches.
